// File: rtl/md5_miner_ctrl.sv
// Proof-of-work sequencer for the md5_top pipeline: builds padded blocks for key||decimal(N).
// It scores the returning digests in order. Optional cycle counter: define MD5_MINER_PERF_EN.
`timescale 1ns/1ps
module md5_miner_ctrl #(
    parameter int MAX_KEY_BYTES = 16,
    parameter int MAX_DIGITS    = 8,
    parameter int ZERO_NIBBLES  = 5,
    parameter int NUM_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [7:0]           key_data,
    input  logic                 key_last,
    output logic                 key_ready,
    input  logic                 md5_block_ready,
    output logic                 md5_block_valid,
    output logic [511:0]         md5_block_data,
    input  logic                 digest_valid,
    input  logic [127:0]         digest_data,
    output logic                 result_valid,
    output logic                 result_error,
    output logic [NUM_WIDTH-1:0] result_number,
    output logic [31:0]          cycle_count
);
    localparam int KEY_W = MAX_KEY_BYTES * 8;
    localparam int BCD_W = MAX_DIGITS * 4;
    localparam int KL_W  = $clog2(MAX_KEY_BYTES + 1);
    localparam int ND_W  = $clog2(MAX_DIGITS + 1);
    localparam int OUT_W = 16;
    localparam logic [KL_W-1:0] KEY_CAP = KL_W'(MAX_KEY_BYTES);
    localparam logic [ND_W-1:0] DIG_CAP = ND_W'(MAX_DIGITS);

    if (MAX_KEY_BYTES + MAX_DIGITS > 55) begin : g_bad_size
        $fatal(1, "md5_miner_ctrl: key plus digits do not fit in one block");
    end
    if (ZERO_NIBBLES < 1 || ZERO_NIBBLES > 32) begin : g_bad_nibbles
        $fatal(1, "md5_miner_ctrl: ZERO_NIBBLES must be 1..32");
    end

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_FLUSH, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic [KL_W-1:0]       key_len_q, key_len_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [ND_W-1:0]       ndig_q, ndig_d;
    logic [511:0]          block_q, block_d;
    logic                  valid_q, valid_d;
    logic [NUM_WIDTH-1:0]  score_q, score_d;
    logic [NUM_WIDTH-1:0]  result_q, result_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic                  err_q, err_d;
    logic                  issue, retire, hit, load_blk, nines;

    function automatic logic [511:0] build_block(input logic [KEY_W-1:0] key, input int len,
                                                 input logic [BCD_W-1:0] bcd, input int nd);
        logic [511:0] blk;
        logic [63:0]  bits;
        int           pos;
        blk  = '0;
        bits = 64'(8 * (len + nd));
        for (int k = 0; k < MAX_KEY_BYTES; k++)
            if (k < len) blk[511-8*k -: 8] = key[8*k +: 8];
        for (int k = 0; k <= MAX_KEY_BYTES + MAX_DIGITS; k++) begin
            pos = k - len;
            if (pos >= 0 && pos < nd) blk[511-8*k -: 8] = {4'h3, bcd[4*(nd-1-pos) +: 4]};
            else if (pos == nd)       blk[511-8*k -: 8] = 8'h80;
        end
        for (int j = 0; j < 8; j++)
            blk[511-8*(56+j) -: 8] = bits[8*j +: 8];
        return blk;
    endfunction

    // Even hex characters live in the high nibble of each digest byte.
    function automatic logic digest_hit(input logic [127:0] d);
        logic m;
        m = 1'b1;
        for (int c = 0; c < ZERO_NIBBLES; c++) begin
            if (c % 2 == 0) begin
                if (d[8*(c/2)+4 +: 4] != 4'h0) m = 1'b0;
            end else begin
                if (d[8*(c/2) +: 4] != 4'h0) m = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [BCD_W-1:0] v, input logic [ND_W-1:0] nd);
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i < int'(nd) && v[4*i +: 4] != 4'd9) r = 1'b0;
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch below can infer a latch.
        state_d   = state_q;
        key_d     = key_q;
        key_len_d = key_len_q;
        bcd_d     = bcd_q;
        ndig_d    = ndig_q;
        block_d   = block_q;
        score_d   = score_q;
        result_d  = result_q;
        outst_d   = outst_q;
        err_d     = err_q;
        load_blk  = 1'b0;
        issue     = valid_q && md5_block_ready;
        retire    = digest_valid && (state_q == S_RUN || state_q == S_FLUSH);
        // Only an overflow-induced FLUSH still scores: err_q is never set in RUN.
        hit       = retire && (state_q == S_RUN || err_q) && digest_hit(digest_data);
        nines     = all_nines(bcd_q, ndig_q);

        unique case (state_q)
            S_LOAD: begin
                if (key_valid) begin
                    if (key_len_q < KEY_CAP) begin
                        key_d[8*int'(key_len_q) +: 8] = key_data;
                        key_len_d = key_len_q + KL_W'(1);
                    end
                    if (key_last) begin
                        state_d  = S_RUN;
                        bcd_d    = BCD_W'(1);
                        ndig_d   = ND_W'(1);
                        load_blk = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (hit) begin
                    result_d = score_q;
                    state_d  = S_FLUSH;
                end
                if (issue) begin
                    if (nines && ndig_q == DIG_CAP) begin
                        state_d = S_FLUSH;
                        err_d   = !hit;
                    end else begin
                        bcd_d    = bcd_inc(bcd_q);
                        ndig_d   = ndig_q + ND_W'(nines);
                        load_blk = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (hit) begin
                    result_d = score_q;
                    err_d    = 1'b0;
                end
                if (outst_q == '0) state_d = S_DONE;
            end
            S_DONE: ;
        endcase

        if (retire) score_d = score_q + NUM_WIDTH'(1);

        case ({issue, retire})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = (outst_q == '0) ? '0 : outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        valid_d = (state_d == S_RUN);
        if (load_blk) block_d = build_block(key_d, int'(key_len_d), bcd_d, int'(ndig_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            key_len_q <= '0;
            bcd_q     <= '0;
            ndig_q    <= '0;
            block_q   <= '0;
            valid_q   <= 1'b0;
            score_q   <= NUM_WIDTH'(1);
            result_q  <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_len_q <= key_len_d;
            bcd_q     <= bcd_d;
            ndig_q    <= ndig_d;
            block_q   <= block_d;
            valid_q   <= valid_d;
            score_q   <= score_d;
            result_q  <= result_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the key buffer is storage, not control; key_len gates every read, so it needs no reset.
    always_ff @(posedge clk) key_q <= key_d;

`ifdef MD5_MINER_PERF_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q;
        if (state_q == S_RUN || state_q == S_FLUSH) cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_d;
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

    // Digest bits beyond the scored prefix are deliberately ignored.
    logic unused_digest;
    assign unused_digest = ^digest_data;

    assign key_ready       = (state_q == S_LOAD);
    assign md5_block_valid = valid_q;
    assign md5_block_data  = block_q;
    assign result_valid    = (state_q == S_DONE);
    assign result_error    = (state_q == S_DONE) && err_q;
    assign result_number   = result_q;
endmodule

// File: tb/tb_md5_miner_ctrl.sv
// Bench for md5_miner_ctrl: a fixed-latency md5_top stand-in returns chosen digests per N.
// Expected blocks and results are queued by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_md5_miner_ctrl;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         reset, key_valid, key_last, key_ready;
    logic [7:0]   key_data;
    logic         md5_block_ready, md5_block_valid;
    logic [511:0] md5_block_data;
    logic         digest_valid;
    logic [127:0] digest_data;
    logic         result_valid, result_error;
    logic [31:0]  result_number, cycle_count;

    typedef struct { bit err; logic [31:0] num; } res_t;

    logic [511:0] exp_blk_q[$];
    res_t         exp_res_q[$];
    int           checks = 0;
    int           errors = 0;
    int           blk_count = 0;
    int           ready_mode = 0;
    bit           res_seen = 0;
    bit [127:0]   match_mask = '0;
    bit [127:0]   near_mask = '0;

    always #5 clk = ~clk;

    md5_miner_ctrl #(.MAX_KEY_BYTES(16), .MAX_DIGITS(2), .ZERO_NIBBLES(5), .NUM_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_data(key_data), .key_last(key_last), .key_ready(key_ready),
        .md5_block_ready(md5_block_ready), .md5_block_valid(md5_block_valid),
        .md5_block_data(md5_block_data),
        .digest_valid(digest_valid), .digest_data(digest_data),
        .result_valid(result_valid), .result_error(result_error),
        .result_number(result_number), .cycle_count(cycle_count)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Standard MD5 padding of a whole message string into one block.
    function automatic logic [511:0] make_block(input string msg);
        logic [511:0] b;
        logic [63:0]  bits;
        int           len;
        b    = '0;
        len  = msg.len();
        bits = 64'(8 * len);
        for (int i = 0; i < len; i++) b[511-8*i -: 8] = msg[i];
        b[511-8*len -: 8] = 8'h80;
        for (int j = 0; j < 8; j++) b[511-8*(56+j) -: 8] = bits[8*j +: 8];
        return b;
    endfunction

    function automatic int decode_n(input logic [511:0] b);
        int         p = 64;
        int         n = 0;
        int         mul = 1;
        logic [7:0] c;
        for (int k = 0; k < 64; k++)
            if (p == 64 && b[511-8*k -: 8] == 8'h80) p = k;
        for (int k = p - 1; k >= 0; k--) begin
            c = b[511-8*k -: 8];
            if (c < 8'h30 || c > 8'h39) break;
            n   += mul * int'(c - 8'h30);
            mul *= 10;
        end
        return n;
    endfunction

    // Match: hex chars 0..4 zero. Near miss: char 4 (high nibble of byte 2) is 1.
    function automatic logic [127:0] digest_for(input int n);
        if (n >= 0 && n < 128 && match_mask[n]) return {{104{1'b1}}, 24'h0F0000};
        if (n >= 0 && n < 128 && near_mask[n])  return {{104{1'b1}}, 24'h100000};
        return {128{1'b1}};
    endfunction

    // md5_top stand-in: fixed latency, in-order, not cleared by reset.
    initial begin
        bit pv[LAT];
        int pn[LAT];
        bit acc_v;
        int acc_n;
        digest_valid    = 1'b0;
        digest_data     = '0;
        md5_block_ready = 1'b0;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pn[i] = 0; end
        forever begin
            @(negedge clk);
            acc_v = md5_block_valid && md5_block_ready;
            acc_n = acc_v ? decode_n(md5_block_data) : 0;
            @(posedge clk);
            #1;
            for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pn[i] = pn[i-1]; end
            pv[0] = acc_v;
            pn[0] = acc_n;
            digest_valid    = pv[LAT-1];
            digest_data     = digest_for(pn[LAT-1]);
            md5_block_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares accepted blocks, stall stability and the result against the queues.
    initial begin
        logic [511:0] prev_data;
        bit           prev_stall;
        res_t         r;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && md5_block_valid) check("hold", md5_block_data, prev_data);
            if (md5_block_valid && md5_block_ready) begin
                blk_count++;
                if (exp_blk_q.size() != 0) check("block", md5_block_data, exp_blk_q.pop_front());
            end
            prev_stall = md5_block_valid && !md5_block_ready;
            prev_data  = md5_block_data;
            if (!result_valid) res_seen = 1'b0;
            else if (!res_seen) begin
                res_seen = 1'b1;
                if (exp_res_q.size() != 0) begin
                    r = exp_res_q.pop_front();
                    check("result_number", result_number, r.num);
                    check("result_error", result_error, r.err);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got number %0d, required no result", result_number);
                end
            end
        end
    end

    task automatic push_res(input bit err, input int num);
        res_t r;
        r.err = err;
        r.num = num;
        exp_res_q.push_back(r);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        blk_count = 0;
        @(negedge clk);
        check("rst_key_ready", key_ready, 1);
        check("rst_block_valid", md5_block_valid, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_error", result_error, 0);
        check("rst_result_number", result_number, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_block_data", md5_block_data, 0);
    endtask

    task automatic send_key(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1;
            key_valid = 1'b1;
            key_data  = s[i];
            key_last  = (i == s.len() - 1);
        end
        @(negedge clk);
        check("valid_before_last", md5_block_valid, 0);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_last  = 1'b0;
        @(negedge clk);
        check("valid_rise", md5_block_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!(res_seen && exp_res_q.size() == 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_in_time", (res_seen && exp_res_q.size() == 0), 1);
        repeat (3) @(negedge clk);
        check("done_hold_valid", result_valid, 1);
        check("done_block_idle", md5_block_valid, 0);
        check("blk_queue_empty", exp_blk_q.size(), 0);
`ifdef MD5_MINER_PERF_EN
        check("cycle_count_nonzero", (cycle_count != 0), 1);
`else
        check("cycle_count_tied", cycle_count, 0);
`endif
    endtask

    initial begin
        logic [511:0] hand1, hand9, hand10;
        hand1  = {8'h61, 8'h62, 8'h63, 8'h31, 8'h80, {51{8'h00}}, 8'h20, {7{8'h00}}};
        hand9  = {8'h61, 8'h62, 8'h63, 8'h39, 8'h80, {51{8'h00}}, 8'h20, {7{8'h00}}};
        hand10 = {8'h61, 8'h62, 8'h63, 8'h31, 8'h30, 8'h80, {50{8'h00}}, 8'h28, {7{8'h00}}};
        reset     = 1'b1;
        key_valid = 1'b0;
        key_last  = 1'b0;
        key_data  = 8'h00;
        do_reset();

        // Padding, stall hold, digit rollover, lowest-N wins over an in-flight later match.
        match_mask = '0; match_mask[12] = 1'b1; match_mask[14] = 1'b1;
        near_mask  = '0; near_mask[5] = 1'b1;
        ready_mode = 0;
        exp_blk_q.push_back(hand1);
        for (int n = 2; n <= 8; n++) exp_blk_q.push_back(make_block($sformatf("abc%0d", n)));
        exp_blk_q.push_back(hand9);
        exp_blk_q.push_back(hand10);
        for (int n = 11; n <= 12; n++) exp_blk_q.push_back(make_block($sformatf("abc%0d", n)));
        push_res(1'b0, 12);
        send_key("abc");
        repeat (5) @(negedge clk);
        ready_mode = 1;
        wait_done(300);

        // Digit overflow with random stalls: exactly 99 blocks, then error.
        do_reset();
        match_mask = '0; near_mask = '0;
        ready_mode = 2;
        for (int n = 1; n <= 99; n++) exp_blk_q.push_back(make_block($sformatf("abc%0d", n)));
        push_res(1'b1, 0);
        send_key("abc");
        wait_done(2000);
        check("overflow_blocks", blk_count, 99);

        // Overflow FLUSH still scores: the last block matches and clears the error.
        do_reset();
        match_mask = '0; match_mask[99] = 1'b1;
        near_mask  = '0; near_mask[98] = 1'b1;
        ready_mode = 1;
        push_res(1'b0, 99);
        send_key("abc");
        wait_done(2000);
        check("late_match_blocks", blk_count, 99);

        // Reset mid-RUN; stale digest for N=18 drains during LOAD, then a clean rerun.
        do_reset();
        match_mask = '0; match_mask[18] = 1'b1;
        near_mask  = '0;
        for (int n = 1; n <= 3; n++) exp_blk_q.push_back(make_block($sformatf("abcdef%0d", n)));
        send_key("abcdef");
        repeat (20) @(posedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        for (int n = 1; n <= 5; n++) exp_blk_q.push_back(make_block($sformatf("abcdef%0d", n)));
        push_res(1'b0, 18);
        send_key("abcdef");
        wait_done(500);

        // Key longer than the buffer: bytes past 16 are dropped.
        do_reset();
        match_mask = '0; match_mask[2] = 1'b1;
        exp_blk_q.push_back(make_block("ABCDEFGHIJKLMNOP1"));
        exp_blk_q.push_back(make_block("ABCDEFGHIJKLMNOP2"));
        push_res(1'b0, 2);
        send_key("ABCDEFGHIJKLMNOPQRS");
        wait_done(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
